// File: rtl/seq_addsub_pkg.sv
// Shared definitions for the multi-cycle chunked adder/subtractor.
package seq_addsub_pkg;

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_BUSY = 2'd1;
  localparam logic [ST_W-1:0] ST_DONE = 2'd2;

  function automatic int unsigned nchunk(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  // Chunk index width; never narrower than one bit so CHUNK==WIDTH still has an index
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_addsub_if.sv
// Operand/result handshake bundle between ALU decode and the result register.
interface seq_addsub_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, s, cout, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, s, cout, overflow, zero
  );

endinterface

// File: rtl/seq_addsub_add_chunk.sv
// Combinational CHUNK-bit ripple-carry slice shared by every step of an operation.
module seq_addsub_add_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    assign sum[i]  = x[i] ^ y[i] ^ c[i];
    assign c[i+1]  = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor: one CHUNK-bit slice per cycle, with
// valid/ready handshakes on operands and result.
module seq_addsub
  import seq_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  seq_addsub_if.slave bus
);

  localparam int unsigned NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int unsigned IDXW   = idx_width(NCHUNK);
  localparam int unsigned OFFW   = $clog2(WIDTH) + 1;

  logic [ST_W-1:0]  state_q, state_d;
  logic             accept, step;
  logic             in_ready_q, out_valid_q;
  logic [WIDTH-1:0] a_q, b_q, s_q, s_upd;
  logic             carry_q, cout_q, ovf_q, zero_q;
  logic [IDXW-1:0]  idx_q;
  logic [OFFW-1:0]  base;
  logic             last;
  logic [CHUNK-1:0] sl_sum;
  logic             sl_cout, sl_cmsb;

  assign base = OFFW'(idx_q) * OFFW'(CHUNK);
  assign last = (idx_q == IDXW'(NCHUNK - 1));

  seq_addsub_add_chunk #(.CHUNK(CHUNK)) u_add_chunk (
    .x     (a_q[base +: CHUNK]),
    .y     (b_q[base +: CHUNK]),
    .cin   (carry_q),
    .sum   (sl_sum),
    .cout  (sl_cout),
    .c_msb (sl_cmsb)
  );

  // Result with the current chunk merged in; feeds both s and the zero flag
  always_comb begin
    s_upd = s_q;
    s_upd[base +: CHUNK] = sl_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          accept  = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        step = 1'b1;
        if (last) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs registered from the next state; in_ready stays low until the first edge out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= (state_d == ST_IDLE);
      out_valid_q <= (state_d == ST_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (accept) begin
      a_q     <= bus.a;
      b_q     <= bus.sub ? ~bus.b : bus.b;
      carry_q <= bus.sub;
      idx_q   <= '0;
    end else if (step) begin
      s_q     <= s_upd;
      carry_q <= sl_cout;
      idx_q   <= last ? '0 : IDXW'(idx_q + 1'b1);
      if (last) begin
        cout_q <= sl_cout;
        ovf_q  <= sl_cmsb ^ sl_cout;
        zero_q <= (s_upd == '0);
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Directed bench for seq_addsub: CHUNK=4 main instance plus a CHUNK=32 single-cycle instance.
module tb_seq_addsub;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] s;
    logic        c;
    logic        v;
    logic        z;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  seq_addsub_if #(.WIDTH(32)) bif ();
  seq_addsub_if #(.WIDTH(32)) bif1 ();

  seq_addsub #(.WIDTH(32), .CHUNK(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  seq_addsub #(.WIDTH(32), .CHUNK(32)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif1)
  );

  // Issue one operation on the CHUNK=4 instance; lat = edges from accept to out_valid
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic sv, output int lat);
    int guard = 0;
    @(negedge clk);
    while (!bif.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bif.in_ready) begin
      checks++;
      failures++;
      $display("FAIL run_op in_ready: got 0 exp 1 within 50 cycles");
      lat = -1;
      return;
    end
    bif.in_valid = 1'b1;
    bif.a = av;
    bif.b = bv;
    bif.sub = sv;
    @(posedge clk);
    #1;
    bif.in_valid = 1'b0;
    bif.a = $urandom;
    bif.b = $urandom;
    bif.sub = ~sv;
    lat = 0;
    while (!bif.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bif.out_valid, bif.s, bif.cout, bif.overflow, bif.zero} !== 36'h0) begin
      failures++;
      $display("FAIL reset outputs: got ov=%b s=%h c=%b v=%b z=%b exp all 0",
               bif.out_valid, bif.s, bif.cout, bif.overflow, bif.zero);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bif.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset in_ready: got %b exp 1", bif.in_ready);
    end
    checks++;
    if (bif1.in_ready !== 1'b1 || bif1.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset1 in_ready/out_valid: got %b/%b exp 1/0", bif1.in_ready, bif1.out_valid);
    end
  endtask

  task automatic test_add();
    vec_t v [3];
    int   lat;
    v = '{'{32'h00000005, 32'h00000003, 1'b0, 32'h00000008, 1'b0, 1'b0, 1'b0},
          '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1},
          '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0}};
    for (int i = 0; i < 3; i++) begin
      run_op(v[i].a, v[i].b, v[i].sub, lat);
      checks++;
      if (lat !== 8) begin
        failures++;
        $display("FAIL add[%0d] latency: got %0d exp 8", i, lat);
      end
      checks++;
      if ({bif.s, bif.cout, bif.overflow, bif.zero} !== {v[i].s, v[i].c, v[i].v, v[i].z}) begin
        failures++;
        $display("FAIL add[%0d] result: got s=%h c=%b v=%b z=%b exp s=%h c=%b v=%b z=%b", i,
                 bif.s, bif.cout, bif.overflow, bif.zero, v[i].s, v[i].c, v[i].v, v[i].z);
      end
    end
  endtask

  task automatic test_sub();
    vec_t v [3];
    int   lat;
    v = '{'{32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1},
          '{32'h00000003, 32'h00000005, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0},
          '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0}};
    for (int i = 0; i < 3; i++) begin
      run_op(v[i].a, v[i].b, v[i].sub, lat);
      checks++;
      if (lat !== 8) begin
        failures++;
        $display("FAIL sub[%0d] latency: got %0d exp 8", i, lat);
      end
      checks++;
      if ({bif.s, bif.cout, bif.overflow, bif.zero} !== {v[i].s, v[i].c, v[i].v, v[i].z}) begin
        failures++;
        $display("FAIL sub[%0d] result: got s=%h c=%b v=%b z=%b exp s=%h c=%b v=%b z=%b", i,
                 bif.s, bif.cout, bif.overflow, bif.zero, v[i].s, v[i].c, v[i].v, v[i].z);
      end
    end
  endtask

  task automatic test_reset_mid();
    int  guard = 0;
    logic seen_valid = 1'b0;
    bif.out_ready = 1'b1;
    @(negedge clk);
    while (!bif.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    bif.in_valid = 1'b1;
    bif.a = 32'h11111111;
    bif.b = 32'h22222222;
    bif.sub = 1'b0;
    @(posedge clk);
    #1;
    bif.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bif.out_valid, bif.s, bif.cout, bif.overflow, bif.zero} !== 36'h0) begin
      failures++;
      $display("FAIL reset_mid outputs: got ov=%b s=%h c=%b v=%b z=%b exp all 0",
               bif.out_valid, bif.s, bif.cout, bif.overflow, bif.zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bif.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid in_ready: got %b exp 1", bif.in_ready);
    end
    for (int k = 0; k < 12; k++) begin
      if (bif.out_valid) seen_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    checks++;
    if (seen_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid out_valid: got 1 exp 0 for aborted op");
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [34:0] exp_r = {32'h23456789, 3'b000};
    bif.out_ready = 1'b0;
    run_op(32'h12345678, 32'h11111111, 1'b0, lat);
    checks++;
    if (lat !== 8 || {bif.s, bif.cout, bif.overflow, bif.zero} !== exp_r) begin
      failures++;
      $display("FAIL bp first: got lat=%0d s=%h flags=%b exp lat=8 s=%h flags=000",
               lat, bif.s, {bif.cout, bif.overflow, bif.zero}, exp_r[34:3]);
    end
    for (int k = 0; k < 5; k++) begin
      bif.in_valid = 1'b1;
      bif.a = 32'hFFFFFFFF;
      bif.b = 32'h00000001;
      bif.sub = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({bif.out_valid, bif.in_ready, bif.s, bif.cout, bif.overflow, bif.zero} !== {2'b10, exp_r}) begin
        failures++;
        $display("FAIL bp hold[%0d]: got ov=%b ir=%b s=%h flags=%b exp ov=1 ir=0 s=%h flags=000", k,
                 bif.out_valid, bif.in_ready, bif.s, {bif.cout, bif.overflow, bif.zero}, exp_r[34:3]);
      end
    end
    bif.in_valid = 1'b0;
    bif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bif.out_valid !== 1'b0 || bif.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp release: got ov=%b ir=%b exp ov=0 ir=1", bif.out_valid, bif.in_ready);
    end
    run_op(32'h00000010, 32'h00000020, 1'b1, lat);
    checks++;
    if (lat !== 8 || {bif.s, bif.cout, bif.overflow, bif.zero} !== {32'hFFFFFFF0, 3'b000}) begin
      failures++;
      $display("FAIL bp next: got lat=%0d s=%h flags=%b exp lat=8 s=fffffff0 flags=000",
               lat, bif.s, {bif.cout, bif.overflow, bif.zero});
    end
  endtask

  task automatic test_single_cycle();
    vec_t v [2];
    int   lat;
    int   guard;
    v = '{'{32'h00000005, 32'h00000003, 1'b0, 32'h00000008, 1'b0, 1'b0, 1'b0},
          '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0}};
    for (int i = 0; i < 2; i++) begin
      guard = 0;
      @(negedge clk);
      while (!bif1.in_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      bif1.in_valid = 1'b1;
      bif1.a = v[i].a;
      bif1.b = v[i].b;
      bif1.sub = v[i].sub;
      @(posedge clk);
      #1;
      bif1.in_valid = 1'b0;
      bif1.a = 32'hDEADBEEF;
      lat = 0;
      while (!bif1.out_valid && lat < 10) begin
        @(posedge clk);
        #1;
        lat++;
      end
      checks++;
      if (lat !== 1) begin
        failures++;
        $display("FAIL single[%0d] latency: got %0d exp 1", i, lat);
      end
      checks++;
      if ({bif1.s, bif1.cout, bif1.overflow, bif1.zero} !== {v[i].s, v[i].c, v[i].v, v[i].z}) begin
        failures++;
        $display("FAIL single[%0d] result: got s=%h c=%b v=%b z=%b exp s=%h c=%b v=%b z=%b", i,
                 bif1.s, bif1.cout, bif1.overflow, bif1.zero, v[i].s, v[i].c, v[i].v, v[i].z);
      end
    end
  endtask

  initial begin
    bif.in_valid = 1'b0;
    bif.a = '0;
    bif.b = '0;
    bif.sub = 1'b0;
    bif.out_ready = 1'b1;
    bif1.in_valid = 1'b0;
    bif1.a = '0;
    bif1.b = '0;
    bif1.sub = 1'b0;
    bif1.out_ready = 1'b1;
    test_reset();
    test_add();
    test_sub();
    test_reset_mid();
    test_backpressure();
    test_single_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_addsub.md
Name: seq_addsub

Overview:
- Parametrised, multi-cycle adder/subtractor that succeeds the fixed 4-bit ripple adder used in the ALU lab.
- Processes a WIDTH-bit operation CHUNK bits per cycle through a single CHUNK-bit ripple slice, trading latency for area.
- Adds subtract mode, signed-overflow and zero flags, and valid/ready handshakes on both input and output, so it can sit between the ALU decode stage and the result register.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK
CHUNK, 4, bits processed per cycle; 1 <= CHUNK <= WIDTH
NCHUNK (localparam), WIDTH/CHUNK, cycles per operation

Ports:
clk        input   1       clock, rising edge
rst_n      input   1       asynchronous active-low reset
in_valid   input   1       operands and mode valid
in_ready   output  1       block can accept an operation
a          input   WIDTH   operand A
b          input   WIDTH   operand B
sub        input   1       0: a+b, 1: a-b
out_valid  output  1       result valid
out_ready  input   1       consumer accepts result
s          output  WIDTH   sum/difference
cout       output  1       carry out of MSB (for sub: 1 = no borrow)
overflow   output  1       signed two's-complement overflow
zero       output  1       s == 0

Behaviour:
- Reset:
  - Asynchronous assert of rst_n=0 forces state IDLE.
  - Outputs during and after reset: s=0, cout=0, overflow=0, zero=0, out_valid=0, chunk index=0.
  - in_ready=1 from the first edge after release.
  - Reset mid-operation aborts it; no out_valid is produced for the aborted operation.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: latch A=a, B=sub ? ~b : b, carry=sub, idx=0; go to BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle the slice adds A[idx*CHUNK +: CHUNK] + B[same] + carry.
  - The slice result is written into s[same]; carry takes the slice carry-out; idx increments.
  - On the last chunk (idx==NCHUNK-1):
    - cout = slice carry-out.
    - overflow = carry into bit WIDTH-1 XOR slice carry-out.
    - zero = (final s == 0).
    - Go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - s, cout, overflow and zero hold stable while out_ready=0.
  - On out_ready=1: go to IDLE and drop out_valid next cycle.
  - No same-cycle accept of a new operation.
- Latency:
  - Operation accepted at edge T; out_valid rises at edge T+NCHUNK.
  - Minimum issue interval is NCHUNK+2 cycles.
- Operand isolation:
  - a, b and sub are sampled only at acceptance.
  - Input changes, and in_valid while BUSY or DONE, have no effect.
- s during BUSY: partially updated; it is only meaningful when out_valid=1.
- Flags from the previous result hold until the next operation's final chunk overwrites them.
- Width rules:
  - The internal carry is 1 bit; all arithmetic is modulo 2^WIDTH.
  - Subtract is a + ~b + 1.
- CHUNK==WIDTH: NCHUNK=1, single BUSY cycle; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - State enum {IDLE, BUSY, DONE}.
  - The NCHUNK derivation.
  - Index width, $clog2(NCHUNK) with a minimum of 1.
- One natural sub-module, add_chunk: combinational CHUNK-bit ripple slice.
  - Inputs: x, y, cin.
  - Outputs: sum, cout, c_msb (carry into the slice MSB, needed for the overflow flag).
- FSM, operand registers and flag logic stay in seq_addsub.

Test Plan:
- All cases use WIDTH=32, CHUNK=4, NCHUNK=8.
- a=0x00000005, b=0x00000003, sub=0, out_ready=1 -> out_valid exactly 8 cycles after accept; s=0x00000008, cout=0, overflow=0, zero=0.
- a=0xFFFFFFFF, b=0x00000001, sub=0 -> s=0, cout=1, zero=1, overflow=0.
- a=0x7FFFFFFF, b=1, sub=0 -> s=0x80000000, overflow=1, cout=0.
- Subtract cases:
  - 5-5 -> s=0, cout=1, zero=1.
  - 3-5 -> s=0xFFFFFFFE, cout=0, overflow=0.
  - 0x80000000-1 -> s=0x7FFFFFFF, overflow=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid -> s/flags stable, in_ready=0.
  - Drive in_valid with new operands during that window -> they are ignored.
  - out_ready=1 -> IDLE next cycle, and the next operation computes correctly.
- Reset and single-cycle config:
  - Pulse rst_n=0 asynchronously 3 cycles into BUSY -> outputs 0 immediately, no out_valid, in_ready=1 after release.
  - Repeat the first case with CHUNK=32 -> out_valid 1 cycle after accept.
